// File: rtl/mips_pkg.sv
// Opcode, instruction-field and width constants shared by the decode stage, plus the
// opcode-to-control decode function.
package mips_pkg;

  localparam int XLEN      = 32;
  localparam int REG_AW    = 5;
  localparam int OPC_W     = 6;
  localparam int IMM_W     = 16;
  localparam int OPC_LSB   = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_LSB = 0;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;

  typedef struct packed {
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              is_beq;
    logic              is_bne;
    logic              uses_rt;
    logic [REG_AW-1:0] dest;
  } dec_t;

  // Non-writing instructions report destination 0 so no stale register number leaks downstream.
  function automatic dec_t decode(input logic [OPC_W-1:0] opc,
                                  input logic [REG_AW-1:0] rt,
                                  input logic [REG_AW-1:0] rd);
    dec_t d;
    d = '0;
    case (opc)
      OP_RTYPE: begin d.reg_write = 1'b1; d.uses_rt = 1'b1; d.dest = rd; end
      OP_ADDI:  begin d.reg_write = 1'b1; d.dest = rt; end
      OP_LW:    begin d.reg_write = 1'b1; d.mem_read = 1'b1; d.dest = rt; end
      OP_SW:    begin d.mem_write = 1'b1; d.uses_rt = 1'b1; end
      OP_BEQ:   begin d.is_beq = 1'b1; d.uses_rt = 1'b1; end
      OP_BNE:   begin d.is_bne = 1'b1; d.uses_rt = 1'b1; end
      default:  d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two combinational read ports, one write port, r0 reads as zero.
// Defining ID_WB_BYPASS_EN forwards a same-cycle write to matching read ports.
module reg_file
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] REG_INIT = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [XLEN-1:0]   rdata1_o,
  output logic [XLEN-1:0]   rdata2_o
);

  logic [XLEN-1:0] regs_q [1:31];

  // Register storage; r0 has no storage at all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= REG_INIT;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read port 1.
  always_comb begin
    rdata1_o = 32'h0000_0000;
    if (raddr1_i == 5'd0) begin
      rdata1_o = 32'h0000_0000;
`ifdef ID_WB_BYPASS_EN
    end else if (we_i && (raddr1_i == waddr_i)) begin
      rdata1_o = wdata_i;
`endif
    end else begin
      rdata1_o = regs_q[raddr1_i];
    end
  end

  // Read port 2.
  always_comb begin
    rdata2_o = 32'h0000_0000;
    if (raddr2_i == 5'd0) begin
      rdata2_o = 32'h0000_0000;
`ifdef ID_WB_BYPASS_EN
    end else if (we_i && (raddr2_i == waddr_i)) begin
      rdata2_o = wdata_i;
`endif
    end else begin
      rdata2_o = regs_q[raddr2_i];
    end
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, register file, decode, load-use stall, branch resolution
// and the ID/EX register. ID_WB_BYPASS_EN enables same-cycle writeback forwarding.
module id_stage
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] REG_INIT = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   if_instr,
  input  logic              if_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              stall,
  output logic              control,
  output logic [IMM_W-1:0]  branch_offset,
  output logic              id_valid,
  output logic [OPC_W-1:0]  id_opcode,
  output logic [5:0]        id_funct,
  output logic [XLEN-1:0]   id_rs_data,
  output logic [XLEN-1:0]   id_rt_data,
  output logic [XLEN-1:0]   id_imm,
  output logic [REG_AW-1:0] id_dest,
  output logic              id_reg_write,
  output logic              id_mem_read,
  output logic              id_mem_write
);

  logic [XLEN-1:0]   ifid_instr_q;
  logic              ifid_valid_q;
  logic [OPC_W-1:0]  opcode;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic [IMM_W-1:0]  imm16;
  logic [XLEN-1:0]   rs_data;
  logic [XLEN-1:0]   rt_data;
  dec_t              dec;
  logic              hz;
  logic              taken;

  assign opcode = ifid_instr_q[OPC_LSB +: OPC_W];
  assign rs     = ifid_instr_q[RS_LSB +: REG_AW];
  assign rt     = ifid_instr_q[RT_LSB +: REG_AW];
  assign rd     = ifid_instr_q[RD_LSB +: REG_AW];
  assign imm16  = ifid_instr_q[0 +: IMM_W];
  assign dec    = decode(opcode, rt, rd);

  reg_file #(.REG_INIT(REG_INIT)) u_reg_file (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (wb_we),
    .waddr_i  (wb_addr),
    .wdata_i  (wb_data),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (rs_data),
    .rdata2_o (rt_data)
  );

  // Load-use hazard, branch resolution and offset; rt is only compared when the opcode reads it.
  always_comb begin
    hz = ifid_valid_q && ex_mem_read && (ex_rt != 5'd0) &&
         ((ex_rt == rs) || (dec.uses_rt && (ex_rt == rt)));
    if (ifid_valid_q && !hz) begin
      taken = (dec.is_beq && (rs_data == rt_data)) || (dec.is_bne && (rs_data != rt_data));
    end else begin
      taken = 1'b0;
    end
    if (dec.is_beq || dec.is_bne) begin
      branch_offset = imm16;
    end else begin
      branch_offset = 16'h0000;
    end
  end

  assign stall   = hz;
  assign control = taken;

  // IF/ID register: a taken branch squashes the fetched slot, a stall holds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_instr_q <= 32'h0000_0000;
      ifid_valid_q <= 1'b0;
    end else if (taken) begin
      ifid_instr_q <= if_instr;
      ifid_valid_q <= 1'b0;
    end else if (!hz) begin
      ifid_instr_q <= if_instr;
      ifid_valid_q <= if_valid;
    end else begin
      ifid_instr_q <= ifid_instr_q;
      ifid_valid_q <= ifid_valid_q;
    end
  end

  // ID/EX register: stalls and empty slots enter execute as all-zero bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid     <= 1'b0;
      id_opcode    <= 6'h00;
      id_funct     <= 6'h00;
      id_rs_data   <= 32'h0000_0000;
      id_rt_data   <= 32'h0000_0000;
      id_imm       <= 32'h0000_0000;
      id_dest      <= 5'd0;
      id_reg_write <= 1'b0;
      id_mem_read  <= 1'b0;
      id_mem_write <= 1'b0;
    end else if (hz || !ifid_valid_q) begin
      id_valid     <= 1'b0;
      id_opcode    <= 6'h00;
      id_funct     <= 6'h00;
      id_rs_data   <= 32'h0000_0000;
      id_rt_data   <= 32'h0000_0000;
      id_imm       <= 32'h0000_0000;
      id_dest      <= 5'd0;
      id_reg_write <= 1'b0;
      id_mem_read  <= 1'b0;
      id_mem_write <= 1'b0;
    end else begin
      id_valid     <= 1'b1;
      id_opcode    <= opcode;
      id_funct     <= ifid_instr_q[FUNCT_LSB +: 6];
      id_rs_data   <= rs_data;
      id_rt_data   <= rt_data;
      id_imm       <= {{(XLEN-IMM_W){imm16[IMM_W-1]}}, imm16};
      id_dest      <= dec.dest;
      id_reg_write <= dec.reg_write;
      id_mem_read  <= dec.mem_read;
      id_mem_write <= dec.mem_write;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios with a queue of expected ID/EX contents.
module tb_id_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stall;
  logic        control;
  logic [15:0] branch_offset;
  logic        id_valid;
  logic [5:0]  id_opcode;
  logic [5:0]  id_funct;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_dest;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;

  id_stage dut (
    .clk(clk), .rst_n(rst_n), .if_instr(if_instr), .if_valid(if_valid),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .stall(stall), .control(control), .branch_offset(branch_offset),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        rw;
    logic        mr;
    logic        mw;
  } idex_t;

  localparam logic [31:0] ADDI_R1 = 32'h2001_0005;
  localparam logic [31:0] ADD_R3  = 32'h0041_1820;
  localparam logic [31:0] ADDI_R5 = 32'h2005_0003;
  localparam logic [31:0] ADDI_R6 = 32'h2006_0007;
  localparam logic [31:0] ADD_R7  = 32'h0081_3820;
  localparam logic [31:0] ADD_R8  = 32'h0000_4020;
  localparam logic [31:0] ADDI_R9 = 32'h2029_0001;
  localparam logic [31:0] LW_R10  = 32'h8C4A_0008;
  localparam logic [31:0] SW_R1   = 32'hAC41_FFFC;
  localparam logic [31:0] ADD_R11 = 32'h0022_5820;
  localparam logic [31:0] OTHER   = 32'hFC00_0000;
  localparam logic [31:0] BEQ_11  = 32'h1021_0004;
  localparam logic [31:0] BNE_11  = 32'h1421_0004;
  localparam logic [31:0] BNE_12  = 32'h1422_0008;
  localparam logic [31:0] BEQ_40  = 32'h1080_0002;
`ifdef ID_WB_BYPASS_EN
  localparam logic [31:0] EXP_R4 = 32'hDEAD_BEEF;
  localparam logic        EXP_BR = 1'b1;
`else
  localparam logic [31:0] EXP_R4 = 32'h0000_0000;
  localparam logic        EXP_BR = 1'b0;
`endif

  idex_t sb[$];
  bit    dq[$];
  idex_t e;
  idex_t o;
  bit    d;
  int    checks = 0;
  int    errors = 0;

  function automatic idex_t mk(input logic v, input logic [5:0] opc, input logic [5:0] fn,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic [31:0] imm, input logic [4:0] dest,
                               input logic rw, input logic mr, input logic mw);
    idex_t x;
    x = '{valid: v, opc: opc, fn: fn, rs: rs, rt: rt, imm: imm, dest: dest, rw: rw, mr: mr, mw: mw};
    return x;
  endfunction

  // Snapshot of the ID/EX outputs; dest is masked for instructions that do not write.
  function automatic idex_t sample(input bit dchk);
    idex_t x;
    x = '{valid: id_valid, opc: id_opcode, fn: id_funct, rs: id_rs_data, rt: id_rt_data,
          imm: id_imm, dest: (dchk ? id_dest : 5'd0), rw: id_reg_write, mr: id_mem_read,
          mw: id_mem_write};
    return x;
  endfunction

  task automatic push(input idex_t x, input bit dchk);
    sb.push_back(x);
    dq.push_back(dchk);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic v);
    if_instr = instr;
    if_valid = v;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({stall, control, branch_offset} !== 18'h0) begin
      errors++; $display("FAIL reset_ctrl: got %h expected 0", {stall, control, branch_offset});
    end
    push(mk(1'b0, 6'h00, 6'h00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0), 1'b1);
    e = sb.pop_front(); d = dq.pop_front(); o = sample(d); checks++;
    if (o !== e) begin errors++; $display("FAIL reset_idex: got %h expected %h", o, e); end
    drive(BEQ_11, 1'b1);
    tick;
    checks++;
    if (control !== 1'b0) begin errors++; $display("FAIL reset_hold: got %b expected 0", control); end
    rst_n = 1'b1;
    drive(32'h0, 1'b0);
  endtask

  task automatic test_addi;
    drive(ADDI_R1, 1'b1);
    push(mk(1'b1, 6'h08, 6'h05, 32'h0, 32'h0, 32'h5, 5'd1, 1'b1, 1'b0, 1'b0), 1'b1);
    tick;
    drive(32'h0, 1'b0);
    checks++;
    if (id_valid !== 1'b0) begin errors++; $display("FAIL addi_latency: got %b expected 0", id_valid); end
    tick;
    e = sb.pop_front(); d = dq.pop_front(); o = sample(d); checks++;
    if (o !== e) begin errors++; $display("FAIL addi_idex: got %h expected %h", o, e); end
    wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'h5;
    tick;
    wb_addr = 5'd2; wb_data = 32'h22;
    tick;
    wb_we = 1'b0;
  endtask

  task automatic test_load_use;
    drive(ADD_R3, 1'b1);
    push(mk(1'b1, 6'h00, 6'h20, 32'h22, 32'h5, 32'h1820, 5'd3, 1'b1, 1'b0, 1'b0), 1'b1);
    tick;
    drive(32'h0, 1'b0); ex_mem_read = 1'b1; ex_rt = 5'd2; #1;
    checks++;
    if ({stall, control} !== 2'b10) begin errors++; $display("FAIL lu_stall: got %b expected 10", {stall, control}); end
    tick;
    checks++;
    if ({id_valid, id_reg_write, id_mem_read, id_mem_write} !== 4'b0) begin
      errors++; $display("FAIL lu_bubble: got %b expected 0000", {id_valid, id_reg_write, id_mem_read, id_mem_write});
    end
    ex_mem_read = 1'b0; ex_rt = 5'd0; #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL lu_release: got %b expected 0", stall); end
    tick;
    e = sb.pop_front(); d = dq.pop_front(); o = sample(d); checks++;
    if (o !== e) begin errors++; $display("FAIL lu_issue: got %h expected %h", o, e); end
    drive(ADDI_R5, 1'b1);
    tick;
    drive(32'h0, 1'b0); ex_mem_read = 1'b1; ex_rt = 5'd5; #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL lu_addi_rt: got %b expected 0", stall); end
    ex_rt = 5'd0; #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL lu_rt_zero: got %b expected 0", stall); end
    ex_mem_read = 1'b0;
    drive(SW_R1, 1'b1);
    tick;
    drive(32'h0, 1'b0); ex_mem_read = 1'b1; ex_rt = 5'd1; #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL lu_sw_rt: got %b expected 1", stall); end
    ex_mem_read = 1'b0; ex_rt = 5'd0;
    tick;
  endtask

  task automatic test_branch;
    drive(BEQ_11, 1'b1);
    push(mk(1'b1, 6'h04, 6'h04, 32'h5, 32'h5, 32'h4, 5'd0, 1'b0, 1'b0, 1'b0), 1'b0);
    tick;
    drive(ADDI_R6, 1'b1); #1;
    checks++;
    if ({control, branch_offset} !== {1'b1, 16'h0004}) begin
      errors++; $display("FAIL beq_taken: got %h expected %h", {control, branch_offset}, {1'b1, 16'h0004});
    end
    tick;
    e = sb.pop_front(); d = dq.pop_front(); o = sample(d); checks++;
    if (o !== e) begin errors++; $display("FAIL beq_idex: got %h expected %h", o, e); end
    drive(32'h0, 1'b0); #1;
    checks++;
    if (control !== 1'b0) begin errors++; $display("FAIL flush_ctrl: got %b expected 0", control); end
    tick;
    checks++;
    if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_bubble: got %b expected 0", id_valid); end
    drive(BNE_11, 1'b1);
    push(mk(1'b1, 6'h05, 6'h04, 32'h5, 32'h5, 32'h4, 5'd0, 1'b0, 1'b0, 1'b0), 1'b0);
    tick;
    drive(ADDI_R6, 1'b1);
    push(mk(1'b1, 6'h08, 6'h07, 32'h0, 32'h0, 32'h7, 5'd6, 1'b1, 1'b0, 1'b0), 1'b1);
    #1;
    checks++;
    if ({control, branch_offset} !== {1'b0, 16'h0004}) begin
      errors++; $display("FAIL bne_not_taken: got %h expected %h", {control, branch_offset}, {1'b0, 16'h0004});
    end
    tick;
    e = sb.pop_front(); d = dq.pop_front(); o = sample(d); checks++;
    if (o !== e) begin errors++; $display("FAIL bne_idex: got %h expected %h", o, e); end
    drive(BNE_12, 1'b1);
    tick;
    e = sb.pop_front(); d = dq.pop_front(); o = sample(d); checks++;
    if (o !== e) begin errors++; $display("FAIL bne_next: got %h expected %h", o, e); end
    drive(32'h0, 1'b0); #1;
    checks++;
    if ({control, branch_offset} !== {1'b1, 16'h0008}) begin
      errors++; $display("FAIL bne_taken: got %h expected %h", {control, branch_offset}, {1'b1, 16'h0008});
    end
    tick;
  endtask

  task automatic test_bypass;
    drive(ADD_R7, 1'b1);
    push(mk(1'b1, 6'h00, 6'h20, EXP_R4, 32'h5, 32'h3820, 5'd7, 1'b1, 1'b0, 1'b0), 1'b1);
    tick;
    drive(32'h0, 1'b0); wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'hDEAD_BEEF;
    tick;
    wb_we = 1'b0;
    e = sb.pop_front(); d = dq.pop_front(); o = sample(d); checks++;
    if (o !== e) begin errors++; $display("FAIL bypass_idex: got %h expected %h", o, e); end
    drive(BEQ_40, 1'b1);
    tick;
    drive(32'h0, 1'b0); wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'h0; #1;
    checks++;
    if (control !== EXP_BR) begin errors++; $display("FAIL bypass_branch: got %b expected %b", control, EXP_BR); end
    tick;
    wb_we = 1'b0;
  endtask

  task automatic test_r0;
    drive(ADD_R8, 1'b1);
    push(mk(1'b1, 6'h00, 6'h20, 32'h0, 32'h0, 32'h4020, 5'd8, 1'b1, 1'b0, 1'b0), 1'b1);
    tick;
    drive(32'h0, 1'b0); wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    tick;
    wb_we = 1'b0;
    e = sb.pop_front(); d = dq.pop_front(); o = sample(d); checks++;
    if (o !== e) begin errors++; $display("FAIL r0_same_cycle: got %h expected %h", o, e); end
    drive(ADD_R8, 1'b1);
    push(mk(1'b1, 6'h00, 6'h20, 32'h0, 32'h0, 32'h4020, 5'd8, 1'b1, 1'b0, 1'b0), 1'b1);
    tick;
    drive(32'h0, 1'b0);
    tick;
    e = sb.pop_front(); d = dq.pop_front(); o = sample(d); checks++;
    if (o !== e) begin errors++; $display("FAIL r0_after: got %h expected %h", o, e); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] prog [5];
    idex_t       exp_v [5];
    bit          dck [5];
    prog = '{ADDI_R9, LW_R10, SW_R1, OTHER, ADD_R11};
    exp_v[0] = mk(1'b1, 6'h08, 6'h01, 32'h5,  32'h0, 32'h1,         5'd9,  1'b1, 1'b0, 1'b0);
    exp_v[1] = mk(1'b1, 6'h23, 6'h08, 32'h22, 32'h0, 32'h8,         5'd10, 1'b1, 1'b1, 1'b0);
    exp_v[2] = mk(1'b1, 6'h2B, 6'h3C, 32'h22, 32'h5, 32'hFFFF_FFFC, 5'd0,  1'b0, 1'b0, 1'b1);
    exp_v[3] = mk(1'b1, 6'h3F, 6'h00, 32'h0,  32'h0, 32'h0,         5'd0,  1'b0, 1'b0, 1'b0);
    exp_v[4] = mk(1'b1, 6'h00, 6'h20, 32'h5,  32'h22, 32'h5820,     5'd11, 1'b1, 1'b0, 1'b0);
    dck = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) begin
        drive(prog[i], 1'b1);
        push(exp_v[i], dck[i]);
      end else begin
        drive(32'h0, 1'b0);
      end
      tick;
      if (i > 0) begin
        e = sb.pop_front(); d = dq.pop_front(); o = sample(d); checks++;
        if (o !== e) begin errors++; $display("FAIL b2b_%0d: got %h expected %h", i - 1, o, e); end
      end
    end
  endtask

  task automatic test_reset_mid_stall;
    drive(ADDI_R9, 1'b1);
    tick;
    drive(ADD_R3, 1'b1);
    tick;
    drive(32'h0, 1'b0); ex_mem_read = 1'b1; ex_rt = 5'd2; #1;
    checks++;
    if ({stall, id_valid} !== 2'b11) begin errors++; $display("FAIL rst_pre: got %b expected 11", {stall, id_valid}); end
    rst_n = 1'b0; #1;
    checks++;
    if ({stall, control, branch_offset, id_valid, id_opcode, id_funct, id_rs_data, id_rt_data,
         id_imm, id_dest, id_reg_write, id_mem_read, id_mem_write} !== 140'h0) begin
      errors++; $display("FAIL rst_mid_stall: got %h expected 0", {stall, control, branch_offset, id_valid,
        id_opcode, id_funct, id_rs_data, id_rt_data, id_imm, id_dest, id_reg_write, id_mem_read, id_mem_write});
    end
    ex_mem_read = 1'b0; ex_rt = 5'd0;
    tick;
    rst_n = 1'b1;
    drive(ADD_R3, 1'b1);
    push(mk(1'b1, 6'h00, 6'h20, 32'h0, 32'h0, 32'h1820, 5'd3, 1'b1, 1'b0, 1'b0), 1'b1);
    tick;
    drive(32'h0, 1'b0);
    tick;
    e = sb.pop_front(); d = dq.pop_front(); o = sample(d); checks++;
    if (o !== e) begin errors++; $display("FAIL rst_regs: got %h expected %h", o, e); end
  endtask

  // Scenario sequence followed by the summary.
  initial begin
    clk = 1'b0; rst_n = 1'b0;
    if_instr = 32'h0; if_valid = 1'b0;
    ex_mem_read = 1'b0; ex_rt = 5'd0;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    test_reset;
    test_addi;
    test_load_use;
    test_branch;
    test_bypass;
    test_r0;
    test_back_to_back;
    test_reset_mid_stall;
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL sb_drain: got %0d expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage that consumes the fetch stage's 32-bit `instruction` stream and returns branch control to it. It sits between the fetch stage and execute, and holds the IF/ID pipeline register, the 32×32 register file, decode, load-use hazard detection and in-stage branch resolution. It drives the fetch stage's `control` (branch taken), `branch_offset` and a stall, and registers decoded operands into the ID/EX register.

## Interface
Parameters:
- `REG_INIT`, 0 — reset value of every register r1..r31.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `if_instr`  in  32  — instruction from the fetch stage.
- `if_valid`  in  1  — `if_instr` is valid this cycle.
- `ex_mem_read`  in  1  — the instruction now in EX is a load.
- `ex_rt`  in  5  — destination register of that load.
- `wb_we`  in  1  — writeback enable.
- `wb_addr`  in  5  — writeback register.
- `wb_data`  in  32  — writeback data.
- `stall`  out  1  — fetch must hold its PC and instruction.
- `control`  out  1  — branch taken; fetch redirects on the next edge.
- `branch_offset`  out  16  — raw `instr[15:0]` of the taken branch; fetch adds sext(offset)<<2.
- `id_valid`  out  1  — ID/EX contents valid.
- `id_opcode`, `id_funct`  out  6 each.
- `id_rs_data`, `id_rt_data`  out  32.
- `id_imm`  out  32  — sign-extended `instr[15:0]`.
- `id_dest`  out  5  — write-destination register.
- `id_reg_write`, `id_mem_read`, `id_mem_write`  out  1 each.

## Operation
- IF/ID register holds `ifid_instr` and `ifid_valid`. It loads `if_instr`/`if_valid` on each edge unless `stall`=1, in which case it holds.
- When `control`=1 at an edge, it loads `ifid_valid`=0 instead (flush). Flush has priority over the load, and there is no delay slot.
- Decode of `ifid_instr` (constants live in `mips_pkg`):
  - opcode 0x00 (R-type): reg_write=1, dest=rd.
  - 0x08 (addi): reg_write=1, dest=rt.
  - 0x23 (lw): mem_read=1, reg_write=1, dest=rt.
  - 0x2B (sw): mem_write=1.
  - 0x04 (beq), 0x05 (bne): branch, no writes.
  - Any other opcode: all controls 0 but `id_valid` follows `ifid_valid`, so the slot behaves as a NOP.
- Load-use hazard: `hz` = `ifid_valid` & `ex_mem_read` & `ex_rt`≠0 & (`ex_rt`==rs | `ex_rt`==rt). For R-type, beq, bne and sw both rs and rt are compared; for others only rs.
- `stall` = `hz`. While stalled:
  - IF/ID holds.
  - ID/EX loads a bubble: `id_valid`=0, all controls 0.
  - `control` is forced to 0.
- Branch: `control` = `ifid_valid` & !`hz` & ((beq & rs_data==rt_data) | (bne & rs_data≠rt_data)). It is combinational from the IF/ID register. `branch_offset` = `ifid_instr[15:0]` whenever a branch is decoded, and 0 otherwise.
- Branch operands come from the register file only. Hazards against non-load EX/MEM results are the compiler's responsibility.
- Register file: r0 always reads 0. A write takes effect at the edge when `wb_we`=1 and `wb_addr`≠0.

## Timing
- Reset (async assert): `ifid_valid`=0, all ID/EX outputs 0, r1..r31=`REG_INIT`. Consequently `stall`, `control` and `branch_offset` are 0.
- Reset release mid-stream: the first instruction is captured at the first edge after `rst_n` rises.
- Latency: instruction at `if_instr` at edge N → in IF/ID after N → on ID/EX outputs after N+1.
- Branch in IF/ID during cycle C: `control`=1 in C; the fetch redirect and the IF/ID flush both happen at the end of C. Net branch penalty is one bubble.
- A load-use stall lasts exactly one cycle, because the load then leaves EX.
- Simultaneous WB write and ID read of the same register: see Configuration.

## Configuration
- `ID_WB_BYPASS_EN` defined: a register-file read whose address equals `wb_addr` (≠0) with `wb_we`=1 returns `wb_data` in the same cycle. This applies to both the ID/EX operands and the branch compare.
- Undefined: the read returns the old value, and the write is visible from the next cycle.

## Structure
- `mips_pkg` holds the opcode constants (`OP_RTYPE`, `OP_ADDI`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_BNE`), the field bit positions and the 32/5-bit width constants.
- One sub-module, `reg_file`: two combinational read ports, one write port, async reset, and the bypass under the macro.

## Test plan
- Reset, then `if_instr`=0x20010005 (addi r1,r0,5) followed by NOPs, with WB looped back to write r1=5 → `id_imm`=5, `id_dest`=1, `id_reg_write`=1 one cycle after capture.
- lw r2 in EX (`ex_mem_read`=1, `ex_rt`=2) with add r3,r2,r1 in IF/ID → `stall`=1 for one cycle, bubble (`id_valid`=0), then the add issues.
- beq r1,r1,+4 (0x10210004) in IF/ID → `control`=1, `branch_offset`=0x0004; the next IF/ID slot is flushed (`ifid_valid`=0).
- bne r1,r1 → `control`=0, and the next instruction proceeds normally.
- WB writes r4=0xDEADBEEF in the same cycle that an add reading r4 sits in IF/ID → `id_rs_data`=0xDEADBEEF with `ID_WB_BYPASS_EN`, the old value without it.
- Write to r0 with 0xFFFFFFFF, then read r0 → 0. Assert `rst_n`=0 mid-stall → all outputs 0 immediately.
